// File: rtl/cpu7_exu_wbarb_pkg.sv
// exu_wb_defs: shared writeback-arbitration types and defaults
package exu_wb_defs;
  localparam int WB_GRLEN = 32;
  localparam int WB_DEPTH = 4;
  localparam int WB_INFLIGHT = 2;
  typedef struct packed {
    logic                valid;
    logic                kill;
    logic [4:0]          rd;
    logic [WB_GRLEN-1:0] data;
  } wb_entry_t;
  typedef enum logic [1:0] {WB_NONE, WB_LSU, WB_BUF, WB_ALU} wb_src_e;
endpackage

// File: rtl/cpu7_exu_wbarb_wbbuf.sv
// cpu7_exu_wbbuf: in-order ALU result buffer with CAM kill and pending-write query
module cpu7_exu_wbbuf
  import exu_wb_defs::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int GRLEN = WB_GRLEN,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_i,
  input  logic [4:0]       enq_rd_i,
  input  logic [GRLEN-1:0] enq_data_i,
  input  logic             pop_i,
  input  logic             pop2_i,
  input  logic             kill_i,
  input  logic [4:0]       kill_rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  output logic [CW-1:0]    cnt_o,
  output logic             hd_kill_o,
  output logic [4:0]       hd_rd_o,
  output logic [GRLEN-1:0] hd_data_o,
  output logic             nx_kill_o,
  output logic [4:0]       nx_rd_o,
  output logic [GRLEN-1:0] nx_data_o,
  output logic             pend_o
);
  logic [DEPTH-1:0] val_q, kil_q;
  logic [4:0]       rd_q  [DEPTH];
  logic [GRLEN-1:0] dat_q [DEPTH];
  logic [PW-1:0]    hd_q, hd_d, tl_q, tl_d, hd1;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full, do_enq;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign cnt_o     = cnt_q;
  assign hd_kill_o = kil_q[hd_q];
  assign hd_rd_o   = rd_q[hd_q];
  assign hd_data_o = dat_q[hd_q];
  assign nx_kill_o = kil_q[hd1];
  assign nx_rd_o   = rd_q[hd1];
  assign nx_data_o = dat_q[hd1];

  // pointer/count next state and the live-entry match against decode sources
  always_comb begin
    hd1    = inc(hd_q);
    full   = cnt_q == CW'(DEPTH);
    do_enq = enq_i && !full;
    hd_d   = pop2_i ? inc(hd1) : pop_i ? hd1 : hd_q;
    tl_d   = do_enq ? inc(tl_q) : tl_q;
    cnt_d  = cnt_q + CW'(do_enq) - CW'(pop_i) - CW'(pop2_i);
    pend_o = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      pend_o |= val_q[i] && !kil_q[i] &&
                ((rs1_i != 5'd0 && rd_q[i] == rs1_i) || (rs2_i != 5'd0 && rd_q[i] == rs2_i));
  end

  // entry storage: kill older matches on a load write, pop from head, push at tail
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
      kil_q <= '0;
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= '0;
    end else begin
      assert (!(enq_i && full)) else $error("wbbuf enqueue while full dropped");
      for (int i = 0; i < DEPTH; i++)
        if (kill_i && val_q[i] && rd_q[i] == kill_rd_i) kil_q[i] <= 1'b1;
      if (pop_i) val_q[hd_q] <= 1'b0;
      if (pop2_i) val_q[hd1] <= 1'b0;
      if (do_enq) begin
        val_q[tl_q] <= 1'b1;
        kil_q[tl_q] <= kill_i && kill_rd_i == enq_rd_i;
        rd_q[tl_q]  <= enq_rd_i;
        dat_q[tl_q] <= enq_data_i;
      end
      hd_q  <= hd_d;
      tl_q  <= tl_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/cpu7_exu_wbarb.sv
// cpu7_exu_wbarb: irf write-port arbiter between load returns and buffered ALU results
module cpu7_exu_wbarb
  import exu_wb_defs::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int GRLEN = WB_GRLEN,
  parameter int INFLIGHT = WB_INFLIGHT,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_wb_valid_m,
  input  logic [4:0]       alu_wb_rd_m,
  input  logic [GRLEN-1:0] alu_wb_data_m,
  input  logic             lsu_wb_valid_m,
  input  logic [4:0]       lsu_wb_rd_m,
  input  logic [GRLEN-1:0] lsu_wb_data_m,
  input  logic [4:0]       dec_rs1_d,
  input  logic [4:0]       dec_rs2_d,
  output logic             wbarb_irf_wen_w,
  output logic [4:0]       wbarb_irf_rd_w,
  output logic [GRLEN-1:0] wbarb_irf_data_w,
  output logic             wbarb_stall_d,
  output logic             wbarb_rs_pend_d,
  output logic [CW-1:0]    wbarb_cnt
);
  logic             lsu_v, alu_v, has1, has2, pop, pop2, alu_dir, enq;
  wb_src_e          src;
  logic             hd_kill, nx_kill;
  logic [4:0]       hd_rd, nx_rd;
  logic [GRLEN-1:0] hd_data, nx_data, buf_data;
  logic [4:0]       buf_rd;
  logic             wen_q, wen_d, stl_q, stl_d;
  logic [4:0]       rd_q, rd_d;
  logic [GRLEN-1:0] data_q, data_d;

  cpu7_exu_wbbuf #(.DEPTH(DEPTH), .GRLEN(GRLEN)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .enq_i     (enq),
    .enq_rd_i  (alu_wb_rd_m),
    .enq_data_i(alu_wb_data_m),
    .pop_i     (pop),
    .pop2_i    (pop2),
    .kill_i    (lsu_v),
    .kill_rd_i (lsu_wb_rd_m),
    .rs1_i     (dec_rs1_d),
    .rs2_i     (dec_rs2_d),
    .cnt_o     (wbarb_cnt),
    .hd_kill_o (hd_kill),
    .hd_rd_o   (hd_rd),
    .hd_data_o (hd_data),
    .nx_kill_o (nx_kill),
    .nx_rd_o   (nx_rd),
    .nx_data_o (nx_data),
    .pend_o    (wbarb_rs_pend_d)
  );

  assign wbarb_irf_wen_w  = wen_q;
  assign wbarb_irf_rd_w   = rd_q;
  assign wbarb_irf_data_w = data_q;
  assign wbarb_stall_d    = stl_q;

  // pick the port owner: load, then buffer head (skipping one killed head), then new ALU result
  always_comb begin
    lsu_v    = lsu_wb_valid_m && lsu_wb_rd_m != 5'd0;
    alu_v    = alu_wb_valid_m && alu_wb_rd_m != 5'd0;
    has1     = wbarb_cnt != '0;
    has2     = wbarb_cnt > CW'(1);
    pop      = !lsu_v && has1;
    pop2     = pop && hd_kill && has2 && !nx_kill;
    alu_dir  = alu_v && !lsu_v && (!has1 || (hd_kill && !has2));
    enq      = alu_v && !alu_dir;
    src      = lsu_v ? WB_LSU : ((pop && !hd_kill) || pop2) ? WB_BUF : alu_dir ? WB_ALU : WB_NONE;
    buf_rd   = hd_kill ? nx_rd : hd_rd;
    buf_data = hd_kill ? nx_data : hd_data;
    wen_d    = src != WB_NONE;
    rd_d     = src == WB_LSU ? lsu_wb_rd_m : src == WB_BUF ? buf_rd : src == WB_ALU ? alu_wb_rd_m : rd_q;
    data_d   = src == WB_LSU ? lsu_wb_data_m : src == WB_BUF ? buf_data : src == WB_ALU ? alu_wb_data_m : data_q;
    stl_d    = int'(wbarb_cnt) + int'(enq) >= DEPTH - INFLIGHT;
  end

  // W-stage write port and registered decode stall
  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q  <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      stl_q  <= 1'b0;
    end else begin
      wen_q  <= wen_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      stl_q  <= stl_d;
    end
  end
endmodule

// File: tb/tb_cpu7_exu_wbarb.sv
// tb_cpu7_exu_wbarb: directed plus randomized check of the writeback arbiter against a queue model
module tb_cpu7_exu_wbarb;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_wb_valid_m = 1'b0, lsu_wb_valid_m = 1'b0;
  logic [4:0]  alu_wb_rd_m = '0, lsu_wb_rd_m = '0, dec_rs1_d = '0, dec_rs2_d = '0;
  logic [31:0] alu_wb_data_m = '0, lsu_wb_data_m = '0;
  logic        wen, stall, pend;
  logic [4:0]  rd;
  logic [31:0] data;
  logic [2:0]  cnt;

  always #5 clk = ~clk;

  cpu7_exu_wbarb dut (
    .clk(clk), .reset(reset),
    .alu_wb_valid_m(alu_wb_valid_m), .alu_wb_rd_m(alu_wb_rd_m), .alu_wb_data_m(alu_wb_data_m),
    .lsu_wb_valid_m(lsu_wb_valid_m), .lsu_wb_rd_m(lsu_wb_rd_m), .lsu_wb_data_m(lsu_wb_data_m),
    .dec_rs1_d(dec_rs1_d), .dec_rs2_d(dec_rs2_d),
    .wbarb_irf_wen_w(wen), .wbarb_irf_rd_w(rd), .wbarb_irf_data_w(data),
    .wbarb_stall_d(stall), .wbarb_rs_pend_d(pend), .wbarb_cnt(cnt)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          kill;
  } ent_t;

  ent_t        mq[$];
  logic        m_wen = 1'b0, m_stall = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_rf[32], d_rf[32];
  int          n_chk = 0, n_fail = 0;
  bit [2:0]    iss = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void wr(input logic [4:0] r, input logic [31:0] d);
    m_wen = 1'b1;
    m_rd = r;
    m_data = d;
    m_rf[r] = d;
  endfunction

  function automatic void model_step();
    int   n0;
    bit   lv, av, used;
    ent_t h;
    if (reset) begin
      mq.delete();
      m_wen = 0;
      m_rd = '0;
      m_data = '0;
      m_stall = 0;
      return;
    end
    n0 = mq.size();
    lv = lsu_wb_valid_m && lsu_wb_rd_m != 0;
    av = alu_wb_valid_m && alu_wb_rd_m != 0;
    used = 0;
    m_wen = 0;
    if (lv) begin
      wr(lsu_wb_rd_m, lsu_wb_data_m);
      foreach (mq[i]) if (mq[i].rd == lsu_wb_rd_m) mq[i].kill = 1;
    end else if (n0 > 0) begin
      h = mq.pop_front();
      if (!h.kill) wr(h.rd, h.data);
      else if (mq.size() > 0) begin
        if (!mq[0].kill) begin
          h = mq.pop_front();
          wr(h.rd, h.data);
        end
      end else if (av) begin
        wr(alu_wb_rd_m, alu_wb_data_m);
        used = 1;
      end
    end else if (av) begin
      wr(alu_wb_rd_m, alu_wb_data_m);
      used = 1;
    end
    if (av && !used)
      mq.push_back('{rd: alu_wb_rd_m, data: alu_wb_data_m, kill: lv && lsu_wb_rd_m == alu_wb_rd_m});
    m_stall = (n0 + int'(av && !used)) >= 2;
  endfunction

  function automatic bit m_pend();
    foreach (mq[i])
      if (!mq[i].kill && ((dec_rs1_d != 0 && mq[i].rd == dec_rs1_d) || (dec_rs2_d != 0 && mq[i].rd == dec_rs2_d)))
        return 1;
    return 0;
  endfunction

  task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                      input bit lv, input logic [4:0] lr, input logic [31:0] ld);
    alu_wb_valid_m = av;
    alu_wb_rd_m = ar;
    alu_wb_data_m = ad;
    lsu_wb_valid_m = lv;
    lsu_wb_rd_m = lr;
    lsu_wb_data_m = ld;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (wen) d_rf[rd] = data;
    chk("wen", wen, m_wen);
    chk("rd", rd, m_rd);
    chk("data", data, m_data);
    chk("cnt", cnt, mq.size());
    chk("stall", stall, m_stall);
    chk("pend", pend, m_pend());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = '0;
      d_rf[r] = '0;
    end
    idle();
    idle();
    chk("rst_cnt", cnt, 0);
    chk("rst_wen", wen, 0);
    reset = 0;
    step(1, 5, 'h11, 0, 0, 0);
    chk("first_wen", wen, 1);
    chk("first_rd", rd, 5);
    chk("first_data", data, 'h11);
    chk("first_cnt", cnt, 0);
    step(1, 3, 'hA, 1, 7, 'hB);
    chk("col_rd1", rd, 7);
    chk("col_cnt1", cnt, 1);
    idle();
    chk("col_rd2", rd, 3);
    chk("col_data2", data, 'hA);
    chk("col_cnt2", cnt, 0);
    step(1, 1, 1, 1, 20, 'h20);
    step(1, 2, 2, 1, 21, 'h21);
    step(1, 3, 3, 1, 22, 'h22);
    chk("ord_cnt", cnt, 3);
    chk("ord_stall", stall, 1);
    idle();
    chk("ord_rd1", rd, 1);
    idle();
    chk("ord_rd2", rd, 2);
    idle();
    chk("ord_rd3", rd, 3);
    idle();
    dec_rs1_d = 4;
    step(1, 4, 'h44, 1, 10, 'h10);
    chk("kill_pend_before", pend, 1);
    step(0, 0, 0, 1, 4, 'h99);
    chk("kill_wr_data", data, 'h99);
    chk("kill_pend_after", pend, 0);
    idle();
    chk("kill_pop_wen", wen, 0);
    chk("kill_pop_cnt", cnt, 0);
    chk("kill_r4", d_rf[4], 'h99);
    dec_rs1_d = 0;
    step(1, 0, 'h55, 1, 11, 'h1);
    chk("r0_cnt", cnt, 0);
    dec_rs2_d = 9;
    step(1, 9, 'h9, 1, 12, 'h2);
    chk("q_pend_rs2", pend, 1);
    dec_rs2_d = 0;
    #1;
    chk("q_pend_rs0", pend, 0);
    idle();
    idle();
    step(1, 13, 'h13, 1, 14, 'h14);
    step(1, 15, 'h15, 1, 16, 'h16);
    chk("mid_cnt", cnt, 2);
    reset = 1;
    idle();
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_wen", wen, 0);
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("mid_no_stale", wen, 0);
    end
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      dec_rs1_d = 5'($urandom_range(0, 7));
      dec_rs2_d = 5'($urandom_range(0, 7));
      step(iss[2], 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0,
           5'($urandom_range(0, 7)), $urandom);
      iss = {iss[1:0], !m_stall && ($urandom_range(0, 3) != 0)};
    end
    reset = 0;
    for (int k = 0; k < 8; k++) idle();
    for (int r = 1; r < 32; r++) chk("rf", d_rf[r], m_rf[r]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
